// File: rtl/reg_file_scoreboard.sv
// 32-entry architectural register file with a per-register busy scoreboard.
// Issue reserves destinations via alloc_valid/alloc_ready; write-back returns data and frees them.
module reg_file_scoreboard #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_rd,
  output logic              alloc_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]  wb_data,
  output logic [WIDTH-1:0]  regs [NREGS],
  output logic [NREGS-1:0]  busy,
  output logic [5:0]        outstanding,
  output logic              wb_err
);

  logic              alloc_nonzero;
  logic              wb_nonzero;
  logic              alloc_hits_wb;
  logic              alloc_fire;
  logic              wb_fire;
  logic              alloc_was_busy;
  logic              wb_was_busy;
  logic              cnt_inc;
  logic              cnt_dec;
  logic [NREGS-1:0]  busy_set;
  logic [NREGS-1:0]  busy_clr;
  logic [NREGS-1:0]  busy_next;
  logic [5:0]        outstanding_next;

  assign alloc_nonzero  = (alloc_rd != '0);
  assign wb_nonzero     = (wb_rd != '0);
  assign alloc_hits_wb  = wb_valid && (wb_rd == alloc_rd);
  assign alloc_was_busy = busy[alloc_rd];
  assign wb_was_busy    = busy[wb_rd];

  // A busy destination can still be re-reserved in the very cycle its write-back returns.
  assign alloc_ready = !alloc_nonzero || !alloc_was_busy || alloc_hits_wb;

  assign alloc_fire = alloc_valid && alloc_ready && alloc_nonzero;
  assign wb_fire    = wb_valid && wb_nonzero;

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (alloc_fire) busy_set[alloc_rd] = 1'b1;
    if (wb_fire)    busy_clr[wb_rd]    = 1'b1;
  end

  // Set dominates clear so a same-register alloc + write-back keeps the new reservation.
  always_comb begin
    busy_next    = busy_set | (busy & ~busy_clr);
    busy_next[0] = 1'b0;
  end

  assign cnt_inc = alloc_fire && !alloc_was_busy;
  assign cnt_dec = wb_fire && wb_was_busy && !(alloc_fire && alloc_hits_wb);

  always_comb begin
    outstanding_next = outstanding;
    if (cnt_inc && !cnt_dec)      outstanding_next = outstanding + 6'd1;
    else if (cnt_dec && !cnt_inc) outstanding_next = outstanding - 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      outstanding <= '0;
      wb_err      <= 1'b0;
    end else begin
      busy        <= busy_next;
      outstanding <= outstanding_next;
      if (wb_fire && !wb_was_busy) wb_err <= 1'b1;
    end
  end

  // Entry 0 is only ever loaded by reset, so it reads zero permanently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wb_fire && (wb_rd == ADDR_W'(i))) regs[i] <= wb_data;
      end
    end
  end

`ifndef SYNTHESIS
  a_outstanding_matches_busy: assert property (
    @(posedge clk) disable iff (!rst_n) outstanding == 6'($countones(busy))
  );
  a_reg0_idle: assert property (
    @(posedge clk) disable iff (!rst_n) (regs[0] == '0) && !busy[0]
  );
`endif

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed testbench for reg_file_scoreboard: reservation, write-back, hazards, r0 and error flag.
module tb_reg_file_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [63:0] regs [32];
  logic [31:0] busy;
  logic [5:0]  outstanding;
  logic        wb_err;

  int checks;
  int failures;

  reg_file_scoreboard #(.WIDTH(64), .NREGS(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .regs        (regs),
    .busy        (busy),
    .outstanding (outstanding),
    .wb_err      (wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
  endtask

  function automatic logic [63:0] fill_data(input int i);
    return 64'hA000_0000_0000_0000 | (64'(i) << 32) | 64'(i * 7);
  endfunction

  task automatic test_reset();
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) if (regs[i] !== 64'd0) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL reset_regs: nonzero=%0d required=0", bad); end
    checks++;
    if (busy !== 32'h0) begin failures++; $display("[TB] FAIL reset_busy: got %h required 0", busy); end
    checks++;
    if (outstanding !== 6'd0) begin failures++; $display("[TB] FAIL reset_outstanding: got %0d required 0", outstanding); end
    checks++;
    if (wb_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_err: got %b required 0", wb_err); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alloc_wb();
    alloc_valid = 1'b1; alloc_rd = 5'd5;
    #1;
    checks++;
    if (alloc_ready !== 1'b1) begin failures++; $display("[TB] FAIL alloc5_ready: got %b required 1", alloc_ready); end
    tick();
    idle_inputs();
    checks++;
    if (busy !== 32'h0000_0020) begin failures++; $display("[TB] FAIL alloc5_busy: got %h required 00000020", busy); end
    checks++;
    if (outstanding !== 6'd1) begin failures++; $display("[TB] FAIL alloc5_outstanding: got %0d required 1", outstanding); end
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEADBEEF_CAFEF00D;
    #1;
    checks++;
    if (regs[5] !== 64'd0) begin failures++; $display("[TB] FAIL wb5_not_early: got %h required 0", regs[5]); end
    tick();
    idle_inputs();
    checks++;
    if (regs[5] !== 64'hDEADBEEF_CAFEF00D) begin failures++; $display("[TB] FAIL wb5_data: got %h required deadbeefcafef00d", regs[5]); end
    checks++;
    if (busy !== 32'h0) begin failures++; $display("[TB] FAIL wb5_busy: got %h required 0", busy); end
    checks++;
    if (outstanding !== 6'd0) begin failures++; $display("[TB] FAIL wb5_outstanding: got %0d required 0", outstanding); end
    checks++;
    if (wb_err !== 1'b0) begin failures++; $display("[TB] FAIL wb5_err: got %b required 0", wb_err); end
  endtask

  task automatic test_back_pressure();
    alloc_valid = 1'b1; alloc_rd = 5'd7;
    tick();
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp7_ready_low: got %b required 0", alloc_ready); end
    tick();
    checks++;
    if (busy !== 32'h0000_0080) begin failures++; $display("[TB] FAIL bp7_busy_held: got %h required 00000080", busy); end
    checks++;
    if (outstanding !== 6'd1) begin failures++; $display("[TB] FAIL bp7_outstanding_held: got %0d required 1", outstanding); end
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h1234;
    #1;
    checks++;
    if (alloc_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp7_ready_bypass: got %b required 1", alloc_ready); end
    tick();
    idle_inputs();
    checks++;
    if (regs[7] !== 64'h1234) begin failures++; $display("[TB] FAIL bp7_data: got %h required 1234", regs[7]); end
    checks++;
    if (busy !== 32'h0000_0080) begin failures++; $display("[TB] FAIL bp7_busy_rewon: got %h required 00000080", busy); end
    checks++;
    if (outstanding !== 6'd1) begin failures++; $display("[TB] FAIL bp7_outstanding_same: got %0d required 1", outstanding); end
    checks++;
    if (wb_err !== 1'b0) begin failures++; $display("[TB] FAIL bp7_err: got %b required 0", wb_err); end
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h77;
    tick();
    idle_inputs();
    checks++;
    if (busy !== 32'h0 || outstanding !== 6'd0 || regs[7] !== 64'h77) begin
      failures++;
      $display("[TB] FAIL bp7_release: busy=%h outstanding=%0d regs7=%h required 0/0/77", busy, outstanding, regs[7]);
    end
  endtask

  task automatic test_back_to_back();
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    tick();
    alloc_rd = 5'd4;
    tick();
    alloc_rd = 5'd10;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 64'h333;
    #1;
    checks++;
    if (alloc_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready: got %b required 1", alloc_ready); end
    tick();
    idle_inputs();
    checks++;
    if (busy !== 32'h0000_0410) begin failures++; $display("[TB] FAIL b2b_busy: got %h required 00000410", busy); end
    checks++;
    if (outstanding !== 6'd2) begin failures++; $display("[TB] FAIL b2b_outstanding: got %0d required 2", outstanding); end
    checks++;
    if (regs[3] !== 64'h333) begin failures++; $display("[TB] FAIL b2b_data3: got %h required 333", regs[3]); end
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 64'h444;
    tick();
    wb_rd = 5'd10; wb_data = 64'hA10;
    tick();
    idle_inputs();
    checks++;
    if (busy !== 32'h0 || outstanding !== 6'd0 || wb_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_drain: busy=%h outstanding=%0d err=%b required 0/0/0", busy, outstanding, wb_err);
    end
    checks++;
    if (regs[4] !== 64'h444 || regs[10] !== 64'hA10) begin
      failures++;
      $display("[TB] FAIL b2b_data: regs4=%h regs10=%h required 444/a10", regs[4], regs[10]);
    end
  endtask

  task automatic test_zero_reg();
    alloc_valid = 1'b1; alloc_rd = 5'd0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = '1;
    #1;
    checks++;
    if (alloc_ready !== 1'b1) begin failures++; $display("[TB] FAIL r0_ready: got %b required 1", alloc_ready); end
    tick();
    idle_inputs();
    checks++;
    if (regs[0] !== 64'd0) begin failures++; $display("[TB] FAIL r0_data: got %h required 0", regs[0]); end
    checks++;
    if (busy !== 32'h0) begin failures++; $display("[TB] FAIL r0_busy: got %h required 0", busy); end
    checks++;
    if (outstanding !== 6'd0) begin failures++; $display("[TB] FAIL r0_outstanding: got %0d required 0", outstanding); end
    checks++;
    if (wb_err !== 1'b0) begin failures++; $display("[TB] FAIL r0_err: got %b required 0", wb_err); end
  endtask

  task automatic test_wb_error();
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 64'h55;
    tick();
    idle_inputs();
    checks++;
    if (regs[9] !== 64'h55) begin failures++; $display("[TB] FAIL err_data: got %h required 55", regs[9]); end
    checks++;
    if (wb_err !== 1'b1) begin failures++; $display("[TB] FAIL err_set: got %b required 1", wb_err); end
    checks++;
    if (outstanding !== 6'd0) begin failures++; $display("[TB] FAIL err_outstanding: got %0d required 0", outstanding); end
    for (int i = 0; i < 100; i++) tick();
    checks++;
    if (wb_err !== 1'b1) begin failures++; $display("[TB] FAIL err_sticky: got %b required 1", wb_err); end
  endtask

  task automatic test_fill();
    int bad;
    for (int i = 1; i < 32; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i);
      tick();
    end
    idle_inputs();
    checks++;
    if (outstanding !== 6'd31) begin failures++; $display("[TB] FAIL fill_outstanding: got %0d required 31", outstanding); end
    checks++;
    if (busy !== 32'hFFFF_FFFE) begin failures++; $display("[TB] FAIL fill_busy: got %h required fffffffe", busy); end
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    #1;
    checks++;
    if (alloc_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_ready3: got %b required 0", alloc_ready); end
    idle_inputs();
    bad = 0;
    for (int i = 31; i >= 1; i--) begin
      wb_valid = 1'b1; wb_rd = 5'(i); wb_data = fill_data(i);
      tick();
      if (outstanding !== 6'(i - 1)) bad++;
    end
    idle_inputs();
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL drain_steps: wrong_steps=%0d required 0", bad); end
    bad = 0;
    for (int i = 1; i < 32; i++) if (regs[i] !== fill_data(i)) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL drain_data: wrong_regs=%0d required 0", bad); end
    checks++;
    if (busy !== 32'h0) begin failures++; $display("[TB] FAIL drain_busy: got %h required 0", busy); end
  endtask

  task automatic test_reset_mid();
    int bad;
    alloc_valid = 1'b1; alloc_rd = 5'd12;
    tick();
    alloc_rd = 5'd20;
    tick();
    idle_inputs();
    checks++;
    if (busy !== 32'h0010_1000) begin failures++; $display("[TB] FAIL pre_reset_busy: got %h required 00101000", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    bad = 0;
    for (int i = 0; i < 32; i++) if (regs[i] !== 64'd0) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL midreset_regs: nonzero=%0d required 0", bad); end
    checks++;
    if (busy !== 32'h0 || outstanding !== 6'd0) begin
      failures++;
      $display("[TB] FAIL midreset_busy: busy=%h outstanding=%0d required 0/0", busy, outstanding);
    end
    checks++;
    if (wb_err !== 1'b0) begin failures++; $display("[TB] FAIL midreset_err: got %b required 0", wb_err); end
    bad = 0;
    alloc_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      alloc_rd = 5'(i);
      #1;
      if (alloc_ready !== 1'b1) bad++;
    end
    idle_inputs();
    checks++;
    if (bad != 0) begin failures++; $display("[TB] FAIL midreset_ready: not_ready=%0d required 0", bad); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_alloc_wb();
    test_back_pressure();
    test_back_to_back();
    test_zero_reg();
    test_wb_error();
    test_fill();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- 32-entry architectural register file with a per-register busy scoreboard.
- Holds register state and exposes it as a registered 32-element array, which feeds the 32:1 operand-select mux instances directly downstream.
- Issue logic reserves destination registers through a valid/ready handshake.
- Write-back returns results and clears the reservation.

Parameters:
- WIDTH, 64, data width of each register; must equal the downstream mux WIDTH.
- NREGS, 32, number of registers. Fixed at 32; the array shape matches the downstream mux input.
- ADDR_W, 5, register address width. Equals $clog2(NREGS); not overridable.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- alloc_valid  input  1  issue requests reservation of alloc_rd.
- alloc_rd  input  ADDR_W  destination register to reserve.
- alloc_ready  output  1  reservation can be accepted this cycle.
- wb_valid  input  1  write-back of wb_data to wb_rd this cycle (no back-pressure).
- wb_rd  input  ADDR_W  write-back destination.
- wb_data  input  WIDTH  write-back value.
- regs  output  WIDTH x NREGS (unpacked [NREGS])  current register contents; wired to the downstream mux in[].
- busy  output  NREGS  per-register reservation bits.
- outstanding  output  6  count of busy registers (0..31).
- wb_err  output  1  sticky: write-back to a non-busy nonzero register occurred.

Behaviour:
- Reset (async assert, sync release to clk):
  - all regs = 0, busy = 0, outstanding = 0, wb_err = 0.
  - Reset mid-operation discards all reservations and data immediately, without waiting for clk.
- Register 0 is hardwired:
  - regs[0] always reads 0, busy[0] always 0.
  - A write-back to rd 0 is ignored, with no error.
  - An allocation of rd 0 is always accepted and has no effect.
- regs and busy are flops only; there is no combinational path from wb_* or alloc_* to regs, busy or outstanding. Write-back data is visible on regs one cycle after wb_valid.
- alloc_ready (combinational) = (alloc_rd == 0) OR !busy[alloc_rd] OR (wb_valid AND wb_rd == alloc_rd).
- Allocation fires when alloc_valid AND alloc_ready. On the next edge busy[alloc_rd] = 1 (for alloc_rd != 0).
- alloc_valid held with alloc_ready low has no effect. The requester holds alloc_rd stable until the allocation fires.
- Write-back (wb_valid, wb_rd != 0):
  - On the next edge regs[wb_rd] = wb_data and busy[wb_rd] = 0, unless the same-register case below applies.
  - If busy[wb_rd] was 0: data is still written and wb_err is set to 1. wb_err stays 1 until reset.
- Simultaneous allocation fire and write-back, same nonzero register: data is written, busy stays 1 (new reservation wins), outstanding unchanged.
- Simultaneous, different registers: both take effect independently.
- outstanding update per edge:
  - +1 for a fired allocation of a nonzero, non-busy register.
  - -1 for a write-back to a busy nonzero register.
  - Net of both when they occur together.
  - Invariant: outstanding == popcount(busy). Maximum 31; no wrap.

Test Plan:
- Reset: drive rst_n=0 mid-run with regs populated and busy set -> immediately regs all 0, busy=0, outstanding=0, wb_err=0; alloc_ready=1 for every rd.
- Alloc rd=5, then wb rd=5 data=0xDEADBEEF_CAFEF00D -> busy[5]=1 and outstanding=1 after alloc; one cycle after wb, regs[5]=0xDEADBEEF_CAFEF00D, busy[5]=0, outstanding=0.
- Back-pressure: rd=7 busy, alloc_valid rd=7 with no wb -> alloc_ready=0 and busy unchanged. Same cycle with wb rd=7 data=0x1234 -> alloc_ready=1; next cycle regs[7]=0x1234, busy[7]=1, outstanding unchanged.
- Zero register: alloc rd=0 and wb rd=0 data=all-ones -> alloc_ready=1, regs[0]=0, busy[0]=0, outstanding=0, wb_err=0.
- Error: wb rd=9 data=0x55 with busy[9]=0 -> regs[9]=0x55, wb_err=1 and remains 1 through 100 further cycles; outstanding unchanged.
- Fill: allocate rd 1..31 on consecutive cycles -> outstanding reaches 31, busy=0xFFFFFFFE. Write back all 31 in reverse order -> outstanding steps down to 0, and each regs[i] matches its written data.
